spi_cs_sck: RTL and testbench

// - SPI master timing generator: on a start request, produces raw active-low cs and sck
//   for one DATA_WIDTH-bit frame, plus per-bit shift/sample strobes for the datapath.
// - Drives the cs/sck delay/duty stage directly; the shift register consumes the strobes.
// - Resolution is one clk; odd-N duty correction is left to the downstream delay stage.

---
 rtl/spi_cs_sck.sv | 160 ++++++++++++++++
 tb/tb_spi_cs_sck.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cs_sck.sv
// SPI master timing generator: produces raw active-low cs and sck for one frame
// plus registered per-bit shift/sample strobes for the datapath.
module spi_cs_sck #(
  parameter int system_clk = 50_000_000,
  parameter int spi_rate   = 5_000_000,
  parameter int DATA_WIDTH = 8,
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpol,
  input  logic          cpha,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          cs,
  output logic          sck,
  output logic          shift_en,
  output logic          sample_en,
  output logic [BW-1:0] bit_idx
);

  localparam int RATIO = system_clk / spi_rate;
  localparam int N     = (RATIO < 4) ? 4 : RATIO;
  localparam int HA    = N / 2;
  localparam int HI    = N - HA;
  localparam int CW    = $clog2(HI + 1);
  localparam int EW    = $clog2(2 * DATA_WIDTH + 1);

  localparam logic [CW-1:0] HA_M1      = CW'(HA - 1);
  localparam logic [CW-1:0] HI_M1      = CW'(HI - 1);
  localparam logic [EW-1:0] LAST_EDGE  = EW'(2 * DATA_WIDTH);
  localparam logic [EW-1:0] LAST_SHIFT = EW'(2 * DATA_WIDTH - 2);
  localparam logic [BW-1:0] TOP_BIT    = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, GAP} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [EW-1:0] edge_cnt, edge_d, edge_nxt;
  logic          cs_d, sck_d, busy_d, done_d, shift_d, sample_d;
  logic [BW-1:0] bit_d;
  logic          cpol_q, cpha_q, cpol_d, cpha_d;
  logic          fire;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    edge_d   = edge_cnt;
    edge_nxt = edge_cnt + EW'(1);
    cs_d     = cs;
    sck_d    = sck;
    busy_d   = busy;
    done_d   = 1'b0;
    shift_d  = 1'b0;
    sample_d = 1'b0;
    bit_d    = bit_idx;
    cpol_d   = cpol_q;
    cpha_d   = cpha_q;
    fire     = 1'b0;

    // bit_idx trails each sample strobe by one cycle and parks at 0
    if (sample_en && bit_idx != '0) bit_d = bit_idx - BW'(1);

    unique case (state)
      IDLE: begin
        sck_d = cpol;
        cs_d  = 1'b1;
        bit_d = TOP_BIT;
        if (start && !busy) begin
          state_d = LEAD;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = HI_M1;
          edge_d  = '0;
          cpol_d  = cpol;
          cpha_d  = cpha;
          shift_d = !cpha;
        end
      end
      LEAD, XFER: begin
        if (cnt == '0) fire = 1'b1;
        else           cnt_d = cnt - CW'(1);
      end
      TRAIL: begin
        if (cnt == '0) begin
          cs_d    = 1'b1;
          done_d  = 1'b1;
          state_d = GAP;
          cnt_d   = HA_M1;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      GAP: begin
        if (cnt == '0) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // An sck edge: odd edges open the active half, even edges the idle half.
    if (fire) begin
      edge_d = edge_nxt;
      sck_d  = ~sck;
      if (edge_nxt == LAST_EDGE) begin
        state_d = TRAIL;
        cnt_d   = HI_M1;
      end else begin
        state_d = XFER;
        cnt_d   = edge_nxt[0] ? HA_M1 : HI_M1;
      end
      if (cpha_q) begin
        shift_d  = edge_nxt[0];
        sample_d = !edge_nxt[0];
      end else begin
        sample_d = edge_nxt[0];
        shift_d  = !edge_nxt[0] && (edge_nxt <= LAST_SHIFT);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; async reset clears
  // every register so an aborted frame leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      edge_cnt  <= '0;
      cs        <= 1'b1;
      sck       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      shift_en  <= 1'b0;
      sample_en <= 1'b0;
      bit_idx   <= TOP_BIT;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      edge_cnt  <= edge_d;
      cs        <= cs_d;
      sck       <= sck_d;
      busy      <= busy_d;
      done      <= done_d;
      shift_en  <= shift_d;
      sample_en <= sample_d;
      bit_idx   <= bit_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
    end
  end

endmodule

// File: tb/tb_spi_cs_sck.sv
// Bench for spi_cs_sck: three instances (N=10, 5, clamped 4) checked every cycle
// against a frame-offset timing model, plus literal per-frame totals.
module tb_spi_cs_sck;

  localparam int DW = 8;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cpol = 1'b0;
  logic cpha = 1'b0;
  logic start = 1'b0;

  logic       cs_w[NI], sck_w[NI], busy_w[NI], done_w[NI], sh_w[NI], sa_w[NI];
  logic [2:0] bi_w[NI];

  always #5 clk = ~clk;

  spi_cs_sck #(.system_clk(50_000_000), .spi_rate(5_000_000), .DATA_WIDTH(DW)) u0 (
    .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha), .start(start),
    .busy(busy_w[0]), .done(done_w[0]), .cs(cs_w[0]), .sck(sck_w[0]),
    .shift_en(sh_w[0]), .sample_en(sa_w[0]), .bit_idx(bi_w[0]));

  spi_cs_sck #(.system_clk(25_000_000), .spi_rate(5_000_000), .DATA_WIDTH(DW)) u1 (
    .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha), .start(start),
    .busy(busy_w[1]), .done(done_w[1]), .cs(cs_w[1]), .sck(sck_w[1]),
    .shift_en(sh_w[1]), .sample_en(sa_w[1]), .bit_idx(bi_w[1]));

  spi_cs_sck #(.system_clk(10_000_000), .spi_rate(5_000_000), .DATA_WIDTH(DW)) u2 (
    .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha), .start(start),
    .busy(busy_w[2]), .done(done_w[2]), .cs(cs_w[2]), .sck(sck_w[2]),
    .shift_en(sh_w[2]), .sample_en(sa_w[2]), .bit_idx(bi_w[2]));

  function automatic int n_of(int i);
    case (i)
      0:       return 10;
      1:       return 5;
      default: return 4;
    endcase
  endfunction

  // Cycle offset (cs-low cycle 1 = 1) at which sck edge e becomes visible.
  function automatic int edge_time(int n, int e);
    int ha = n / 2;
    int hi = n - ha;
    return 1 + hi + (e / 2) * ha + ((e - 1) / 2) * hi;
  endfunction

  function automatic int edges_by(int n, int k);
    int c = 0;
    for (int e = 1; e <= 2 * DW; e++) if (edge_time(n, e) <= k) c++;
    return c;
  endfunction

  function automatic int edge_now(int n, int k);
    for (int e = 1; e <= 2 * DW; e++) if (edge_time(n, e) == k) return e;
    return 0;
  endfunction

  function automatic int cs_lit(int i);
    case (i)
      0:       return 85;
      1:       return 43;
      default: return 34;
    endcase
  endfunction

  function automatic int busy_lit(int i);
    case (i)
      0:       return 90;
      1:       return 45;
      default: return 36;
    endcase
  endfunction

  // Behavioural model: expected outputs follow from the offset k inside a frame.
  bit act_m[NI];
  bit lpol_m[NI], lpha_m[NI];
  int k_m[NI];
  int x_cs[NI], x_sck[NI], x_busy[NI], x_done[NI], x_sh[NI], x_sa[NI], x_bit[NI];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        act_m[i] = 1'b0; k_m[i] = 0;
        x_cs[i] = 1; x_sck[i] = 0; x_busy[i] = 0; x_done[i] = 0;
        x_sh[i] = 0; x_sa[i] = 0; x_bit[i] = DW - 1;
      end else if (act_m[i]) begin : frame
        int n, hi, e;
        n  = n_of(i);
        hi = n - n / 2;
        if (x_sa[i] != 0 && x_bit[i] > 0) x_bit[i]--;
        k_m[i]++;
        if (k_m[i] == DW * n + n + 1) begin
          act_m[i] = 1'b0;
          x_busy[i] = 0; x_cs[i] = 1; x_done[i] = 0; x_sh[i] = 0; x_sa[i] = 0;
        end else begin
          x_busy[i] = 1;
          x_cs[i]   = int'(k_m[i] > DW * n + hi);
          x_done[i] = int'(k_m[i] == DW * n + hi + 1);
          x_sck[i]  = int'(lpol_m[i]) ^ (edges_by(n, k_m[i]) % 2);
          e = edge_now(n, k_m[i]);
          x_sa[i] = int'(e != 0 && (lpha_m[i] ? (e % 2 == 0) : (e % 2 == 1)));
          x_sh[i] = int'(e != 0 && (lpha_m[i] ? (e % 2 == 1) : (e % 2 == 0 && e <= 2 * DW - 2)));
        end
      end else begin
        x_cs[i] = 1; x_sck[i] = int'(cpol); x_busy[i] = 0; x_done[i] = 0;
        x_sh[i] = 0; x_sa[i] = 0; x_bit[i] = DW - 1;
        if (start) begin
          act_m[i] = 1'b1; k_m[i] = 1;
          lpol_m[i] = cpol; lpha_m[i] = cpha;
          x_busy[i] = 1; x_cs[i] = 0; x_sh[i] = int'(!cpha);
        end
      end
    end
  end

  int total = 0;
  int passed = 0;
  int m_cslow[NI], m_busy[NI], m_edges[NI], m_done[NI], m_sa[NI], m_sh[NI];
  int s_cslow[NI], s_busy[NI], s_edges[NI], s_done[NI], s_sa[NI], s_sh[NI];
  logic prev_sck[NI];

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual == expected) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("cs[%0d]", i),        int'(cs_w[i]),   x_cs[i]);
      check($sformatf("sck[%0d]", i),       int'(sck_w[i]),  x_sck[i]);
      check($sformatf("busy[%0d]", i),      int'(busy_w[i]), x_busy[i]);
      check($sformatf("done[%0d]", i),      int'(done_w[i]), x_done[i]);
      check($sformatf("shift_en[%0d]", i),  int'(sh_w[i]),   x_sh[i]);
      check($sformatf("sample_en[%0d]", i), int'(sa_w[i]),   x_sa[i]);
      check($sformatf("bit_idx[%0d]", i),   int'(bi_w[i]),   x_bit[i]);
      if (!cs_w[i]) m_cslow[i]++;
      if (busy_w[i]) m_busy[i]++;
      if (done_w[i]) m_done[i]++;
      if (sa_w[i]) m_sa[i]++;
      if (sh_w[i]) m_sh[i]++;
      if (sck_w[i] !== prev_sck[i]) m_edges[i]++;
      prev_sck[i] = sck_w[i];
    end
  endtask

  // One clock: compare mid-cycle, return just after the next rising edge.
  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic snap();
    for (int i = 0; i < NI; i++) begin
      s_cslow[i] = m_cslow[i]; s_busy[i] = m_busy[i]; s_edges[i] = m_edges[i];
      s_done[i] = m_done[i]; s_sa[i] = m_sa[i]; s_sh[i] = m_sh[i];
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_frame(input string tag);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s cs_low[%0d]", tag, i), m_cslow[i] - s_cslow[i], cs_lit(i));
      check($sformatf("%s busy_len[%0d]", tag, i), m_busy[i] - s_busy[i], busy_lit(i));
      check($sformatf("%s sck_edges[%0d]", tag, i), m_edges[i] - s_edges[i], 2 * DW);
      check($sformatf("%s done_cnt[%0d]", tag, i), m_done[i] - s_done[i], 1);
      check($sformatf("%s sample_cnt[%0d]", tag, i), m_sa[i] - s_sa[i], DW);
      check($sformatf("%s shift_cnt[%0d]", tag, i), m_sh[i] - s_sh[i], DW);
      check($sformatf("%s sck_idle[%0d]", tag, i), int'(sck_w[i]), int'(cpol));
    end
  endtask

  initial begin
    int hold;
    hold = 0;
    for (int i = 0; i < NI; i++) begin
      m_cslow[i] = 0; m_busy[i] = 0; m_edges[i] = 0;
      m_done[i] = 0; m_sa[i] = 0; m_sh[i] = 0; prev_sck[i] = 1'b0;
    end

    run(3);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("reset cs[%0d]", i), int'(cs_w[i]), 1);
      check($sformatf("reset sck[%0d]", i), int'(sck_w[i]), 0);
      check($sformatf("reset busy[%0d]", i), int'(busy_w[i]), 0);
      check($sformatf("reset bit_idx[%0d]", i), int'(bi_w[i]), DW - 1);
    end
    rst_n = 1'b1;
    run(2);

    // Hand-computed edge offsets pin the model itself.
    check("model N5 edge1", edge_time(5, 1), 4);
    check("model N5 edge2", edge_time(5, 2), 6);
    check("model N5 edge3", edge_time(5, 3), 9);
    check("model N10 edge16", edge_time(10, 16), 81);
    check("model N4 spacing", edge_time(4, 2) - edge_time(4, 1), 2);

    snap();
    pulse_start();
    run(100);
    check_frame("mode0");

    for (int m = 1; m < 4; m++) begin
      cpol = m[1];
      cpha = m[0];
      run(3);
      snap();
      pulse_start();
      run(100);
      check_frame($sformatf("mode%0d", m));
    end

    // start re-asserted mid-frame must be ignored
    cpol = 1'b0;
    cpha = 1'b0;
    run(3);
    snap();
    pulse_start();
    run(18);
    pulse_start();
    run(100);
    check_frame("busy_start");

    // async reset mid-frame aborts without done
    cpol = 1'b1;
    run(3);
    snap();
    pulse_start();
    run(6);
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("abort cs[%0d]", i), int'(cs_w[i]), 1);
      check($sformatf("abort sck[%0d]", i), int'(sck_w[i]), 0);
      check($sformatf("abort busy[%0d]", i), int'(busy_w[i]), 0);
    end
    run(3);
    for (int i = 0; i < NI; i++)
      check($sformatf("abort no_done[%0d]", i), m_done[i] - s_done[i], 0);
    rst_n = 1'b1;
    run(3);
    snap();
    pulse_start();
    run(100);
    check_frame("after_abort");

    // randomized traffic, including held start and live cpol/cpha changes
    for (int c = 0; c < 3000; c++) begin
      if (hold > 0) begin
        start = 1'b1;
        hold--;
      end else if ($urandom_range(0, 99) == 0) begin
        hold = $urandom_range(50, 250);
        start = 1'b1;
      end else begin
        start = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 9) == 0) cpol = ~cpol;
      if ($urandom_range(0, 9) == 0) cpha = ~cpha;
      if (c == 1500) begin
        #1 rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
      end
      step();
    end
    start = 1'b0;
    run(100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
